// File: rtl/gf_2393_pkg.sv
// Shared constants and state type for the mod-2393 arithmetic datapath
// (serial multiplier and Barrett reducer).
package gf_2393_pkg;

  localparam int unsigned Q     = 2393;
  localparam int unsigned W     = 12;
  localparam int unsigned PW    = 23;
  localparam int unsigned CNT_W = 4;

  localparam logic [W-1:0]     Q_W      = W'(Q);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/mul_serial_2393.sv
// Shift-and-add multiplier: one multiplier bit per cycle, LSB first, with
// valid/ready on both sides; feeds the Barrett reducer for Q = 2393.
module mul_serial_2393
  import gf_2393_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product_o,
  output logic          err_o
);

  state_e             state_q, state_d;
  logic [2*W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_pend_q, err_pend_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic               err_q, err_d;

  logic               accept;
  logic [2*W-1:0]     acc_sum;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign product_o = prod_q;
  assign err_o     = err_q;

  assign acc_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    prod_d     = prod_q;
    err_d      = err_q;

    unique case (state_q)
      BUSY: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        // Outputs are only touched on the final iteration so they stay frozen while BUSY.
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          prod_d  = acc_sum[PW-1:0];
          err_d   = err_pend_q;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    // Shared by IDLE and DONE: in_ready already encodes which state may accept.
    if (accept) begin
      state_d    = BUSY;
      a_sh_d     = {{W{1'b0}}, a_i};
      b_sh_d     = b_i;
      acc_d      = '0;
      cnt_d      = '0;
      err_pend_d = (a_i >= Q_W) || (b_i >= Q_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      prod_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mul_serial_2393.sv
// Self-checking bench for mul_serial_2393: directed corner cases plus a
// randomized sweep with random backpressure against an arithmetic model.
module tb_mul_serial_2393;
  import gf_2393_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product_o;
  logic          err_o;

  mul_serial_2393 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product_o (product_o),
    .err_o     (err_o)
  );

  typedef struct {
    longint prod;
    bit     err;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     rand_ordy = 0;

  bit          last_valid = 0;
  bit          last_taken = 0;
  logic [PW-1:0] last_prod = '0;
  bit          last_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b, input int c);
    exp_t e;
    e.prod = longint'((a * b) % (32'd1 << PW));
    e.err  = (a >= Q) || (b >= Q);
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: sampled on the falling edge, where inputs and outputs are settled
  // for the rising edge that follows.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_valid = 0;
      last_taken = 0;
      last_prod  = '0;
      last_err   = 0;
    end else begin
      if (out_valid && !last_valid) begin
        check_eq("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("latency", cyc - exp_q[0].cyc, W + 1);
      end
      if (out_valid && last_valid && !last_taken) begin
        check_eq("hold_prod", product_o, last_prod);
        check_eq("hold_err", err_o, last_err);
      end
      if (!out_valid) check_eq("frozen_prod", product_o, last_prod);
      if (out_valid && !out_ready) check_eq("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("product", product_o, e.prod);
        check_eq("err", err_o, e.err);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_i, b_i, cyc));
      last_valid = out_valid;
      last_taken = out_valid && out_ready;
      last_prod  = product_o;
      last_err   = err_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int unsigned a, input int unsigned b);
    bit took;
    took = 0;
    in_valid = 1'b1;
    a_i = W'(a);
    b_i = W'(b);
    for (int n = 0; n < 400 && !took; n++) begin
      @(negedge clk);
      if (in_ready) took = 1;
      step();
    end
    check_eq("accept_done", took, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step();
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct { int unsigned a; int unsigned b; } pair_t;
  pair_t directed[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_i       = '0;
    b_i       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_product", product_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", in_ready, 1);

    // Directed products, out_ready held high, back-to-back.
    directed = '{'{2392, 2392}, '{1234, 2000}, '{0, 2392}, '{2392, 1},
                 '{1, 1}, '{2393, 1}, '{4095, 4095}};
    foreach (directed[i]) send(directed[i].a, directed[i].b);
    drain();

    // Backpressure: result held 20 cycles, then consume and accept on one edge.
    out_ready = 1'b0;
    send(100, 200);
    for (int n = 0; n < 50 && !out_valid; n++) step();
    check_eq("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    a_i = W'(5);
    b_i = W'(6);
    repeat (20) begin
      step();
      check_eq("bp_no_accept", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_same_edge_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    drain();

    // Reset in the middle of BUSY; product_o holds a nonzero earlier result.
    send(9, 9);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_product", product_o, 0);
    check_eq("midrst_err", err_o, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send(3, 7);
    drain();

    // Randomized sweep with random backpressure and input gaps.
    rand_ordy = 1;
    for (int i = 0; i < 150; i++) begin
      int unsigned a, b;
      a = $urandom_range(0, Q - 1);
      b = $urandom_range(0, Q - 1);
      if (i % 37 == 0) a = $urandom_range(Q, (1 << W) - 1);
      send(a, b);
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    rand_ordy = 0;
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
